// File: rtl/aidc_lite_concat_arbiter_if.sv
// ---------------------------------------------------------------------------
// aidc_lite_concat_arbiter_if
// Bundle of lane-side request signals and concatenator-side output signals
// for the AIDC-Lite packet arbiter.
//   slave  modport : arbiter view (requests in, ready/outputs out)
//   master modport : lane/concatenator environment view
// Optional: AIDC_LITE_ARB_PERF_EN adds pkt_cnt_o (16-bit per-lane counters).
// Signals:
//   req_valid_i/sop_i/eop_i [N_REQ]        per-lane beat qualifiers
//   req_data_i [N_REQ*DATA_SIZE]           lane k at [k*DATA_SIZE +: DATA_SIZE]
//   req_size_i [N_REQ*7]                   lane k at [k*7 +: 7]
//   req_ready_o [N_REQ]                    per-lane accept, one-hot or zero
//   valid_o/sop_o/eop_o/data_o/size_o      registered beat to concatenator
//   src_id_o [ID_W]                        lane id of the beat on valid_o
//   busy_o, err_o                          packet locked / sticky protocol error
// ---------------------------------------------------------------------------
interface aidc_lite_concat_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 66
) ();
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]           req_valid_i;
  logic [N_REQ-1:0]           req_sop_i;
  logic [N_REQ-1:0]           req_eop_i;
  logic [N_REQ*DATA_SIZE-1:0] req_data_i;
  logic [N_REQ*7-1:0]         req_size_i;
  logic [N_REQ-1:0]           req_ready_o;
  logic                       valid_o;
  logic                       sop_o;
  logic                       eop_o;
  logic [DATA_SIZE-1:0]       data_o;
  logic [6:0]                 size_o;
  logic [ID_W-1:0]            src_id_o;
  logic                       busy_o;
  logic                       err_o;
`ifdef AIDC_LITE_ARB_PERF_EN
  logic [N_REQ*16-1:0]        pkt_cnt_o;
`endif

  modport slave (
    input  req_valid_i, req_sop_i, req_eop_i, req_data_i, req_size_i,
    output req_ready_o, valid_o, sop_o, eop_o, data_o, size_o, src_id_o,
           busy_o, err_o
`ifdef AIDC_LITE_ARB_PERF_EN
    , output pkt_cnt_o
`endif
  );

  modport master (
    output req_valid_i, req_sop_i, req_eop_i, req_data_i, req_size_i,
    input  req_ready_o, valid_o, sop_o, eop_o, data_o, size_o, src_id_o,
           busy_o, err_o
`ifdef AIDC_LITE_ARB_PERF_EN
    , input pkt_cnt_o
`endif
  );
endinterface

// File: rtl/aidc_lite_concat_arbiter.sv
// ---------------------------------------------------------------------------
// aidc_lite_concat_arbiter
// Packet-level round-robin arbiter sharing one AIDC-Lite code-concatenation
// stage among N_REQ compressor lanes. A lane is granted for a whole packet
// (sop..eop); its beats are forwarded through one output register together
// with the source lane id. The concatenator has no backpressure, so lanes
// are throttled via a combinational, one-hot-or-zero ready.
// Ports:
//   clk    clock
//   rst_n  synchronous reset, active-low (control and output register)
//   bus    aidc_lite_concat_arbiter_if.slave (requests, ready, outputs)
// Optional feature macro: AIDC_LITE_ARB_PERF_EN adds per-lane 16-bit
// completed-packet counters on bus.pkt_cnt_o.
// ---------------------------------------------------------------------------
module aidc_lite_concat_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_SIZE = 66
) (
  input  logic                       clk,
  input  logic                       rst_n,
  aidc_lite_concat_arbiter_if.slave  bus
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] owner, owner_nxt;
  logic [ID_W-1:0] rr_ptr, rr_nxt;
  logic [ID_W-1:0] winner, sel;
  logic            found, accept, acc_sop, acc_eop, err_set;
  logic [N_REQ-1:0] ready;
  int              idx;

  logic                 vld_p0, sop_p0, eop_p0, err_p0;
  logic [DATA_SIZE-1:0] data_p0;
  logic [6:0]           size_p0;
  logic [ID_W-1:0]      src_p0;

  // Round-robin successor: wraps N_REQ-1 back to lane 0.
  function automatic logic [ID_W-1:0] next_lane(input logic [ID_W-1:0] lane);
    if (int'(lane) == N_REQ - 1) return '0;
    return lane + ID_W'(1);
  endfunction

  // First lane with valid&sop at or after rr_ptr, searched modulo N_REQ.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid_i[idx] && bus.req_sop_i[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    ready     = '0;
    sel       = owner;
    err_set   = 1'b0;
    if (state == IDLE) begin
      sel = winner;
      if (found) ready[winner] = 1'b1;
      // A lane presenting a mid-packet beat with nothing locked is a protocol error.
      err_set = |(bus.req_valid_i & ~bus.req_sop_i);
    end else begin
      ready[owner] = 1'b1;
      err_set      = bus.req_valid_i[owner] & bus.req_sop_i[owner];
    end
    accept  = |(bus.req_valid_i & ready);
    acc_sop = bus.req_sop_i[sel];
    acc_eop = bus.req_eop_i[sel];
    if (accept) begin
      if (state == IDLE) begin
        if (acc_eop) begin
          rr_nxt = next_lane(winner);
        end else begin
          state_nxt = LOCKED;
          owner_nxt = winner;
        end
      end else if (acc_eop) begin
        state_nxt = IDLE;
        rr_nxt    = next_lane(owner);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Stage p0: accepted lane beat -> concatenator output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      sop_p0  <= 1'b0;
      eop_p0  <= 1'b0;
      err_p0  <= 1'b0;
      data_p0 <= '0;
      size_p0 <= '0;
      src_p0  <= '0;
    end else begin
      vld_p0 <= accept;
      // A repeated sop from the owner is forwarded as a continuation beat.
      sop_p0 <= accept & acc_sop & (state == IDLE);
      eop_p0 <= accept & acc_eop;
      if (err_set) err_p0 <= 1'b1;
      if (accept) begin
        data_p0 <= bus.req_data_i[int'(sel)*DATA_SIZE +: DATA_SIZE];
        size_p0 <= bus.req_size_i[int'(sel)*7 +: 7];
        src_p0  <= sel;
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.valid_o     = vld_p0;
  assign bus.sop_o       = sop_p0;
  assign bus.eop_o       = eop_p0;
  assign bus.data_o      = data_p0;
  assign bus.size_o      = size_p0;
  assign bus.src_id_o    = src_p0;
  assign bus.busy_o      = (state == LOCKED);
  assign bus.err_o       = err_p0;

`ifdef AIDC_LITE_ARB_PERF_EN
  logic [N_REQ*16-1:0] pkt_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (accept && acc_eop) begin
      pkt_cnt[int'(sel)*16 +: 16] <= pkt_cnt[int'(sel)*16 +: 16] + 16'd1;
    end
  end

  assign bus.pkt_cnt_o = pkt_cnt;
`endif
endmodule

// File: tb/tb_aidc_lite_concat_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aidc_lite_concat_arbiter
// Directed bench for aidc_lite_concat_arbiter (N_REQ=4, DATA_SIZE=66).
// Lane traffic comes from per-lane beat queues; a behavioural arbitration
// model predicts ready, error and lock state each cycle and pushes every
// predicted accept into a scoreboard that is popped when the DUT outputs.
// ---------------------------------------------------------------------------
module tb_aidc_lite_concat_arbiter;
  localparam int N  = 4;
  localparam int DW = 66;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
    logic [6:0]    size;
    logic [1:0]    src;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aidc_lite_concat_arbiter_if #(.N_REQ(N), .DATA_SIZE(DW)) bus ();

  aidc_lite_concat_arbiter #(.N_REQ(N), .DATA_SIZE(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  beat_t lq[N][$];
  beat_t sb[$];
  int    stall[N];

  // behavioural model state
  bit m_locked;
  int m_owner;
  int m_rr;
  bit m_err;
  logic [DW-1:0] last_data;
  logic [6:0]    last_size;
  logic [1:0]    last_src;

  int n_assert = 0;
  int n_fail   = 0;
  int seq      = 0;

  // observation logs
  int src_log[$];
  int busy_cnt, vcnt, vrun, vrun_max;
  bit rdy0_seen, rdy3_seen;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    src_log.delete();
    busy_cnt = 0; vcnt = 0; vrun = 0; vrun_max = 0;
    rdy0_seen = 1'b0; rdy3_seen = 1'b0;
  endtask

  task automatic push_pkt(input int k, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      seq++;
      b.sop  = (i == 0);
      b.eop  = (i == nbeats - 1);
      b.data = {2'(k), 32'(seq), $urandom()};
      b.size = (i == 0) ? 7'd6 : 7'd34;
      b.src  = 2'(k);
      lq[k].push_back(b);
    end
  endtask

  task automatic check_src_log(input string tag, input int exp_q[$]);
    chk({tag, "_len"}, 128'(src_log.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < src_log.size(); i++)
      chk({tag, "_lane"}, 128'(src_log[i]), 128'(exp_q[i]));
  endtask

  task automatic drive_idle();
    bus.req_valid_i = '0;
    bus.req_sop_i   = '0;
    bus.req_eop_i   = '0;
    bus.req_data_i  = '0;
    bus.req_size_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    for (int k = 0; k < N; k++) begin
      lq[k].delete();
      stall[k] = 0;
    end
    sb.delete();
    @(posedge clk);
    #1;
    m_locked = 1'b0; m_owner = 0; m_rr = 0; m_err = 1'b0;
    last_data = '0; last_size = '0; last_src = '0;
    chk("rst_valid", 128'(bus.valid_o), 128'(0));
    chk("rst_sop",   128'(bus.sop_o),   128'(0));
    chk("rst_eop",   128'(bus.eop_o),   128'(0));
    chk("rst_busy",  128'(bus.busy_o),  128'(0));
    chk("rst_err",   128'(bus.err_o),   128'(0));
    chk("rst_data",  128'(bus.data_o),  128'(0));
    chk("rst_size",  128'(bus.size_o),  128'(0));
    chk("rst_src",   128'(bus.src_id_o), 128'(0));
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic [N-1:0]    v, s, e, m_ready;
    logic [N*DW-1:0] d;
    logic [N*7-1:0]  sz;
    int    sel, idx;
    bit    acc;
    beat_t b, eb;
    @(negedge clk);
    v = '0; s = '0; e = '0; d = '0; sz = '0;
    for (int k = 0; k < N; k++) begin
      if (lq[k].size() > 0 && stall[k] == 0) begin
        b = lq[k][0];
        v[k] = 1'b1; s[k] = b.sop; e[k] = b.eop;
        d[k*DW +: DW] = b.data;
        sz[k*7 +: 7]  = b.size;
      end
    end
    bus.req_valid_i = v; bus.req_sop_i = s; bus.req_eop_i = e;
    bus.req_data_i = d; bus.req_size_i = sz;
    #1;
    m_ready = '0;
    sel = -1;
    if (!m_locked) begin
      for (int i = 0; i < N; i++) begin
        idx = (m_rr + i) % N;
        if (sel < 0 && v[idx] && s[idx]) sel = idx;
      end
      if (sel >= 0) m_ready[sel] = 1'b1;
      if (|(v & ~s)) m_err = 1'b1;
    end else begin
      sel = m_owner;
      m_ready[sel] = 1'b1;
      if (v[sel] && s[sel]) m_err = 1'b1;
    end
    chk("ready", 128'(bus.req_ready_o), 128'(m_ready));
    if (bus.req_ready_o[0]) rdy0_seen = 1'b1;
    if (bus.req_ready_o[3]) rdy3_seen = 1'b1;
    acc = (sel >= 0) && v[sel];
    if (acc) begin
      b = lq[sel][0];
      if (m_locked) b.sop = 1'b0;
      sb.push_back(b);
    end
    @(posedge clk);
    #1;
    if (acc) begin
      void'(lq[sel].pop_front());
      if (!m_locked) begin
        if (b.eop) m_rr = (sel + 1) % N;
        else begin m_locked = 1'b1; m_owner = sel; end
      end else if (b.eop) begin
        m_locked = 1'b0;
        m_rr = (sel + 1) % N;
      end
    end
    for (int k = 0; k < N; k++) if (stall[k] > 0) stall[k]--;
    chk("valid_o", 128'(bus.valid_o), 128'(acc));
    if (acc) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'(0), 128'(1));
      end else begin
        eb = sb.pop_front();
        chk("sop_o",    128'(bus.sop_o),    128'(eb.sop));
        chk("eop_o",    128'(bus.eop_o),    128'(eb.eop));
        chk("data_o",   128'(bus.data_o),   128'(eb.data));
        chk("size_o",   128'(bus.size_o),   128'(eb.size));
        chk("src_id_o", 128'(bus.src_id_o), 128'(eb.src));
        last_data = eb.data; last_size = eb.size; last_src = eb.src;
      end
    end else begin
      chk("sop_idle",  128'(bus.sop_o),    128'(0));
      chk("eop_idle",  128'(bus.eop_o),    128'(0));
      chk("data_hold", 128'(bus.data_o),   128'(last_data));
      chk("size_hold", 128'(bus.size_o),   128'(last_size));
      chk("src_hold",  128'(bus.src_id_o), 128'(last_src));
    end
    chk("busy_o", 128'(bus.busy_o), 128'(m_locked));
    chk("err_o",  128'(bus.err_o),  128'(m_err));
    if (bus.valid_o === 1'b1) begin
      vcnt++; vrun++;
      if (vrun > vrun_max) vrun_max = vrun;
      if (bus.sop_o === 1'b1) src_log.push_back(int'(bus.src_id_o));
    end else vrun = 0;
    if (bus.busy_o === 1'b1) busy_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    for (int k = 0; k < N; k++) stall[k] = 0;

    // 1: lane2 three-beat packet
    do_reset();
    clear_logs();
    push_pkt(2, 3);
    run(4);
    check_src_log("t1_order", '{2});
    chk("t1_busy_cycles", 128'(busy_cnt), 128'(2));
    chk("t1_beats", 128'(vcnt), 128'(3));

    // 2: all lanes busy from reset, lane0 with a second packet
    do_reset();
    clear_logs();
    for (int k = 0; k < N; k++) push_pkt(k, 2);
    push_pkt(0, 2);
    run(12);
    check_src_log("t2_order", '{0, 1, 2, 3, 0});
    chk("t2_gapless_run", 128'(vrun_max), 128'(10));

    // 3: owner lane1 stalls while lane3 waits
    do_reset();
    clear_logs();
    push_pkt(1, 3);
    step();
    stall[1] = 5;
    push_pkt(3, 2);
    run(5);
    chk("t3_lane3_held", 128'(rdy3_seen), 128'(0));
    run(6);
    check_src_log("t3_order", '{1, 3});
    chk("t3_beats", 128'(vcnt), 128'(5));

    // 4: lane0 valid without sop in IDLE
    do_reset();
    clear_logs();
    begin
      beat_t bad;
      bad.sop = 1'b0; bad.eop = 1'b0; bad.data = '1; bad.size = 7'd9; bad.src = 2'd0;
      lq[0].push_back(bad);
    end
    push_pkt(1, 2);
    step();
    chk("t4_err_set", 128'(bus.err_o), 128'(1));
    run(4);
    lq[0].delete();
    run(2);
    chk("t4_err_sticky", 128'(bus.err_o), 128'(1));
    chk("t4_lane0_never_ready", 128'(rdy0_seen), 128'(0));
    check_src_log("t4_order", '{1});

    // 5: single-beat packets and rr wrap
    do_reset();
    clear_logs();
    push_pkt(2, 1);
    run(2);
    push_pkt(3, 1);
    push_pkt(0, 1);
    run(3);
    push_pkt(0, 1);
    push_pkt(1, 1);
    run(3);
    check_src_log("t5_order", '{2, 3, 0, 1, 0});
    chk("t5_beats", 128'(vcnt), 128'(5));

    // 6: reset mid-packet
    do_reset();
    clear_logs();
    push_pkt(2, 3);
    run(2);
    chk("t6_busy_mid", 128'(bus.busy_o), 128'(1));
    do_reset();
    run(2);
`ifdef AIDC_LITE_ARB_PERF_EN
    chk("t6_cnt_rst", 128'(bus.pkt_cnt_o), 128'(0));
    @(negedge clk);
    bus.req_valid_i = 4'b0001;
    bus.req_sop_i   = 4'b0001;
    bus.req_eop_i   = 4'b0001;
    repeat (65535) @(posedge clk);
    #1;
    chk("t6_cnt_max", 128'(bus.pkt_cnt_o[15:0]), 128'(16'hFFFF));
    @(posedge clk);
    #1;
    chk("t6_cnt_wrap", 128'(bus.pkt_cnt_o[15:0]), 128'(0));
    chk("t6_cnt_others", 128'(bus.pkt_cnt_o[63:16]), 128'(0));
    do_reset();
    chk("t6_cnt_rst2", 128'(bus.pkt_cnt_o), 128'(0));
`endif

    for (int k = 0; k < N; k++) chk("lane_queue_drained", 128'(lq[k].size()), 128'(0));
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
